// File: rtl/rr_grant_encoder.sv
// Round-robin arbiter for 4 requesters with a registered grant index,
// a rotating priority pointer and a hold-time watchdog.
module rr_grant_encoder #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       done,
   output logic [1:0] gnt_idx,
   output logic       gnt_valid,
   output logic       timeout
);

   typedef enum logic {
      ST_IDLE,
      ST_GRANT
   } state_t;

   state_t     r_state, w_state_nxt;
   logic [1:0] r_ptr, w_ptr_nxt;
   logic [1:0] r_idx, w_idx_nxt;
   logic [7:0] r_cnt, w_cnt_nxt;
   logic       r_timeout, w_timeout_nxt;

   logic [1:0] w_sel;
   logic       w_any;
   logic       w_withdraw;
   logic       w_wd;

   // Circular scan starting at the priority pointer; first hit wins.
   always_comb begin
      logic [1:0] v_cand;
      w_sel = '0;
      w_any = 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
         v_cand = r_ptr + 2'(i);
         if (!w_any && req[v_cand]) begin
            w_sel = v_cand;
            w_any = 1'b1;
         end
      end
   end

   assign w_withdraw = ~req[r_idx];
   assign w_wd       = (r_cnt == 8'(MAX_HOLD - 1));

   always_comb begin
      w_state_nxt   = r_state;
      w_ptr_nxt     = r_ptr;
      w_idx_nxt     = r_idx;
      w_cnt_nxt     = r_cnt;
      w_timeout_nxt = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_idx_nxt   = w_sel;
               w_cnt_nxt   = '0;
               w_state_nxt = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (done || w_withdraw || w_wd) begin
               w_state_nxt   = ST_IDLE;
               w_ptr_nxt     = r_idx + 2'd1;
               w_cnt_nxt     = '0;
               // Timeout flags only a release the owner did not cause itself.
               w_timeout_nxt = ~done & ~w_withdraw;
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_ptr     <= '0;
         r_idx     <= '0;
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_ptr     <= w_ptr_nxt;
         r_idx     <= w_idx_nxt;
         r_cnt     <= w_cnt_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   assign gnt_idx   = r_idx;
   assign gnt_valid = (r_state == ST_GRANT);
   assign timeout   = r_timeout;

endmodule
